load_align_unit: RTL and testbench

//  Sequential load-data aligner for the cpu55 memory stage. It is the parametrised successor of the combinational word/half/byte selector.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/load_extend.sv | 36 +++
 rtl/load_align_unit.sv | 120 ++++++++++++
 tb/tb_load_align_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared load/store path definitions: access-size encodings, aligner FSM states
// and the byte-count helper.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational byte extractor: picks 2^size bytes starting at byte off of a
// two-word window and sign/zero-extends them to XLEN.
module load_extend
  import mem_pkg::*;
#(
  parameter int  XLEN  = 32,
  localparam int OFF_W = $clog2(XLEN/8)
) (
  input  logic [2*XLEN-1:0] window,
  input  logic [OFF_W-1:0]  off,
  input  logic [1:0]        size,
  input  logic              sgn,
  output logic [XLEN-1:0]   result
);

  localparam int IDX_W = $clog2(XLEN);

  logic [XLEN-1:0]  sel;
  logic [IDX_W-1:0] msb_idx;
  logic             fill;
  int               nbits;

  always_comb begin
    sel   = XLEN'(window >> {off, 3'b000});
    nbits = 8 << size;
    // A full-width access has no bits above its MSB, so the fill never applies.
    if (nbits >= XLEN) msb_idx = IDX_W'(XLEN - 1);
    else               msb_idx = IDX_W'(nbits - 1);
    fill   = sgn & sel[msb_idx];
    result = '0;
    for (int i = 0; i < XLEN; i++) begin
      result[i] = (i < nbits) ? sel[i] : fill;
    end
  end

endmodule

// File: rtl/load_align_unit.sv
// Sequential load-data aligner: takes one load request, consumes one or two
// memory beats and returns the extracted, extended result.
module load_align_unit
  import mem_pkg::*;
#(
  parameter int  XLEN           = 32,
  parameter bit  ALLOW_MISALIGN = 1'b1,
  localparam int OFF_W          = $clog2(XLEN/8)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OFF_W-1:0] req_off,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic             beat_valid,
  output logic             beat_ready,
  input  logic [XLEN-1:0]  beat_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic             out_err,
  output state_t           state
);

  localparam int NB = XLEN/8;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid, and flush forces every ready low.
  state_t              state_next;
  logic [OFF_W-1:0]    off_q;
  logic [1:0]          size_q;
  logic                sgn_q;
  logic [XLEN-1:0]     beat0_q;
  logic                req_bad;
  logic                span;
  logic                take_req;
  logic                take_beat;
  logic [2*XLEN-1:0]   window;
  logic [XLEN-1:0]     ext_data;

  assign req_bad = ((XLEN == 32) && (req_size == SZ_D)) ||
                   (!ALLOW_MISALIGN &&
                    ((req_off & OFF_W'(size_bytes(req_size) - 4'd1)) != '0));
  assign span      = (5'(off_q) + 5'(size_bytes(size_q))) > 5'(NB);
  assign take_req  = req_valid && req_ready;
  assign take_beat = beat_valid && beat_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (req_valid)  state_next = req_bad ? DONE : BEAT0;
        BEAT0:   if (beat_valid) state_next = span ? BEAT1 : DONE;
        BEAT1:   if (beat_valid) state_next = DONE;
        DONE:    if (out_ready)  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready  = (state == IDLE) && !flush;
    beat_ready = ((state == BEAT0) || (state == BEAT1)) && !flush;
    out_valid  = (state == DONE);
  end

  // In BEAT1 the stored first beat supplies the low bytes, the live beat the high ones.
  assign window = (state == BEAT1) ? {beat_data, beat0_q} : {{XLEN{1'b0}}, beat_data};

  load_extend #(.XLEN(XLEN)) u_extend (
    .window (window),
    .off    (off_q),
    .size   (size_q),
    .sgn    (sgn_q),
    .result (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q    <= '0;
      size_q   <= SZ_B;
      sgn_q    <= 1'b0;
      beat0_q  <= '0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else begin
      if (take_req) begin
        off_q  <= req_off;
        size_q <= req_size;
        sgn_q  <= req_signed;
        if (req_bad) begin
          out_data <= '0;
          out_err  <= 1'b1;
        end
      end
      if (take_beat && (state == BEAT0)) begin
        beat0_q <= beat_data;
        if (!span) begin
          out_data <= ext_data;
          out_err  <= 1'b0;
        end
      end
      if (take_beat && (state == BEAT1)) begin
        out_data <= ext_data;
        out_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: 32-bit misalign-capable, 32-bit strict
// and 64-bit instances driven from one step sequence with a result scoreboard.
module tb_load_align_unit;
  import mem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush      [3];
  logic        req_valid  [3];
  logic [2:0]  req_off    [3];
  logic [1:0]  req_size   [3];
  logic        req_signed [3];
  logic        beat_valid [3];
  logic [63:0] beat_data  [3];
  logic        out_ready  [3];
  wire         req_ready  [3];
  wire         beat_ready [3];
  wire         out_valid  [3];
  wire         out_err    [3];
  wire  [1:0]  st         [3];
  wire  [31:0] od0;
  wire  [31:0] od1;
  wire  [63:0] od2;

  logic [64:0] exp_q [$];
  int n_checks;
  int n_err;

  load_align_unit #(.XLEN(32), .ALLOW_MISALIGN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_off(req_off[0][1:0]),
    .req_size(req_size[0]), .req_signed(req_signed[0]),
    .beat_valid(beat_valid[0]), .beat_ready(beat_ready[0]), .beat_data(beat_data[0][31:0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(od0),
    .out_err(out_err[0]), .state(st[0])
  );

  load_align_unit #(.XLEN(32), .ALLOW_MISALIGN(1'b0)) dut_strict (
    .clk(clk), .rst_n(rst_n), .flush(flush[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_off(req_off[1][1:0]),
    .req_size(req_size[1]), .req_signed(req_signed[1]),
    .beat_valid(beat_valid[1]), .beat_ready(beat_ready[1]), .beat_data(beat_data[1][31:0]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(od1),
    .out_err(out_err[1]), .state(st[1])
  );

  load_align_unit #(.XLEN(64), .ALLOW_MISALIGN(1'b1)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush[2]),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_off(req_off[2]),
    .req_size(req_size[2]), .req_signed(req_signed[2]),
    .beat_valid(beat_valid[2]), .beat_ready(beat_ready[2]), .beat_data(beat_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(od2),
    .out_err(out_err[2]), .state(st[2])
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] odata(input int k);
    case (k)
      0:       return {32'b0, od0};
      1:       return {32'b0, od1};
      default: return od2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: one load on instance k; the expected result is queued at request time.
  task automatic load(input int k, input int off, input logic [1:0] size, input bit sgn,
                      input logic [63:0] b0, input logic [63:0] b1, input int nb,
                      input logic [63:0] exp_d, input bit exp_e, input int hold);
    logic [64:0] exp;
    int cyc;
    int bi;
    bit took;
    exp_q.push_back({exp_e, exp_d});
    req_valid[k]  = 1'b1;
    req_off[k]    = 3'(off);
    req_size[k]   = size;
    req_signed[k] = sgn;
    out_ready[k]  = 1'b0;
    #1;
    chk("req_ready_idle", req_ready[k], 1);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    cyc = 0;
    bi  = 0;
    while (!out_valid[k] && cyc < 8) begin
      beat_valid[k] = 1'b1;
      beat_data[k]  = (bi == 0) ? b0 : b1;
      #1;
      took = beat_ready[k];
      @(posedge clk); #1;
      cyc++;
      if (took) bi++;
    end
    beat_valid[k] = 1'b0;
    chk("latency_cycles", cyc, nb);
    chk("beats_consumed", bi, nb);
    chk("out_valid", out_valid[k], 1);
    exp = exp_q.pop_front();
    chk("out_data", odata(k), exp[63:0]);
    chk("out_err", out_err[k], exp[64]);
    for (int h = 0; h < hold; h++) begin
      beat_valid[k] = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", out_valid[k], 1);
      chk("hold_data", odata(k), exp[63:0]);
      chk("hold_err", out_err[k], exp[64]);
      chk("hold_beat_ready", beat_ready[k], 0);
    end
    beat_valid[k] = 1'b0;
    out_ready[k]  = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    chk("out_valid_drop", out_valid[k], 0);
    chk("back_to_idle", st[k], IDLE);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    for (int k = 0; k < 3; k++) begin
      flush[k] = 1'b0; req_valid[k] = 1'b0; req_off[k] = '0; req_size[k] = '0;
      req_signed[k] = 1'b0; beat_valid[k] = 1'b0; beat_data[k] = '0; out_ready[k] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_req_ready", req_ready[k], 1);
      chk("rst_beat_ready", beat_ready[k], 0);
      chk("rst_out_valid", out_valid[k], 0);
      chk("rst_out_err", out_err[k], 0);
      chk("rst_out_data", odata(k), 0);
      chk("rst_state", st[k], IDLE);
    end

    // Aligned and single-beat extraction on the 32-bit instance
    load(0, 0, SZ_W, 1'b0, 64'hf0f0f0f0, 64'h0, 1, 64'hf0f0f0f0, 1'b0, 0);
    load(0, 2, SZ_H, 1'b1, 64'h80f01234, 64'h0, 1, 64'hffff80f0, 1'b0, 0);
    load(0, 2, SZ_H, 1'b0, 64'h80f01234, 64'h0, 1, 64'h000080f0, 1'b0, 0);
    load(0, 3, SZ_B, 1'b1, 64'hf0f0f0f0, 64'h0, 1, 64'hfffffff0, 1'b0, 0);
    load(0, 3, SZ_B, 1'b0, 64'hf0f0f0f0, 64'h0, 1, 64'h000000f0, 1'b0, 0);
    load(0, 0, SZ_B, 1'b1, 64'h0000007f, 64'h0, 1, 64'h0000007f, 1'b0, 0);
    load(0, 1, SZ_H, 1'b1, 64'h11228344, 64'h0, 1, 64'h00002283, 1'b0, 0);

    // Boundary-crossing loads, one with a stalled consumer
    load(0, 3, SZ_H, 1'b1, 64'h5a000000, 64'h000000a5, 2, 64'hffffa55a, 1'b0, 0);
    load(0, 3, SZ_W, 1'b0, 64'haabbccdd, 64'h11223344, 2, 64'h223344aa, 1'b0, 3);

    // Illegal size on 32-bit, misaligned on the strict instance
    load(0, 0, SZ_D, 1'b0, 64'h12345678, 64'h0, 0, 64'h0, 1'b1, 0);
    load(1, 3, SZ_W, 1'b0, 64'haabbccdd, 64'h11223344, 0, 64'h0, 1'b1, 2);
    load(1, 2, SZ_H, 1'b1, 64'h80f01234, 64'h0, 1, 64'hffff80f0, 1'b0, 0);

    // 64-bit instance
    load(2, 0, SZ_D, 1'b1, 64'h8000000000000001, 64'h0, 1, 64'h8000000000000001, 1'b0, 0);
    load(2, 6, SZ_W, 1'b1, 64'h8877665544332211, 64'hffeeddccbbaa9988, 2,
         64'hffffffff99888877, 1'b0, 1);
    load(2, 4, SZ_H, 1'b0, 64'h0000c3b200000000, 64'h0, 1, 64'h000000000000c3b2, 1'b0, 0);

    // Flush while waiting for the second beat
    req_valid[0] = 1'b1; req_off[0] = 3'd3; req_size[0] = SZ_W; req_signed[0] = 1'b0;
    @(posedge clk); #1;
    req_valid[0] = 1'b0; beat_valid[0] = 1'b1; beat_data[0] = 64'haabbccdd;
    @(posedge clk); #1;
    chk("flush_pre_state", st[0], BEAT1);
    flush[0] = 1'b1; beat_data[0] = 64'h11223344;
    #1;
    chk("flush_beat_ready", beat_ready[0], 0);
    chk("flush_req_ready", req_ready[0], 0);
    @(posedge clk); #1;
    flush[0] = 1'b0; beat_valid[0] = 1'b0;
    chk("flush_state", st[0], IDLE);
    chk("flush_no_valid", out_valid[0], 0);
    @(posedge clk); #1;
    chk("flush_no_valid_later", out_valid[0], 0);

    // Flush wins over a simultaneous request
    flush[0] = 1'b1; req_valid[0] = 1'b1; req_off[0] = 3'd0; req_size[0] = SZ_W;
    #1;
    chk("flush_req_blocked", req_ready[0], 0);
    @(posedge clk); #1;
    chk("flush_req_state", st[0], IDLE);
    flush[0] = 1'b0; req_valid[0] = 1'b0;
    load(0, 0, SZ_W, 1'b0, 64'h01020304, 64'h0, 1, 64'h01020304, 1'b0, 0);

    // Asynchronous reset in the middle of a two-beat merge
    req_valid[0] = 1'b1; req_off[0] = 3'd2; req_size[0] = SZ_W; req_signed[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0; beat_valid[0] = 1'b1; beat_data[0] = 64'hdeadbeef;
    @(posedge clk); #1;
    chk("rst_mid_pre_state", st[0], BEAT1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_data", odata(0), 0);
    chk("rst_mid_err", out_err[0], 0);
    chk("rst_mid_valid", out_valid[0], 0);
    chk("rst_mid_beat_ready", beat_ready[0], 0);
    chk("rst_mid_state", st[0], IDLE);
    beat_valid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    load(0, 0, SZ_W, 1'b0, 64'h12345678, 64'h0, 1, 64'h12345678, 1'b0, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
